collision_scheduler: RTL and testbench

- Front-end controller for the segment collision checker in the print-path validator.
- Accepts 3D line segments from the toolpath parser over a valid/ready handshake and stores them in a local segment table.
- For each new segment, sequences pairwise requests to an external single-pair checker against every earlier, unflagged segment, stopping at the first hit.
- Reports one verdict per segment, carrying a 1-based lineID.

---
 rtl/collision_scheduler.sv | 165 ++++++++++++++++
 tb/tb_collision_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scheduler.sv
// Front-end scheduler for the segment collision checker: stores incoming 3D
// segments and compares each new one against earlier unflagged segments.
module collision_scheduler #(
  parameter int MAX_LINES = 51,
  parameter int CW        = 8,
  parameter int IDW       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [CW-1:0]     x1,
  input  logic [CW-1:0]     y1,
  input  logic [CW-1:0]     z1,
  input  logic [CW-1:0]     x2,
  input  logic [CW-1:0]     y2,
  input  logic [CW-1:0]     z2,
  input  logic              clr,
  output logic              chk_req,
  output logic [6*CW-1:0]   chk_a,
  output logic [6*CW-1:0]   chk_b,
  input  logic              chk_ack,
  input  logic              chk_hit,
  output logic              out_val,
  output logic [IDW-1:0]    lineID,
  output logic              collide,
  output logic [IDW-1:0]    collide_cnt,
  output logic              full,
  output logic              busy
);

  localparam int SW = 6 * CW;
  localparam int AW = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CHECK,
    REPORT
  } state_t;

  state_t               state, state_d;
  logic [IDW-1:0]       ct;
  logic [IDW-1:0]       i;
  logic [IDW-1:0]       limit;
  logic [SW-1:0]        cur;
  logic [SW-1:0]        seg;
  logic [SW-1:0]        mem [MAX_LINES];
  logic [MAX_LINES-1:0] flag;
  logic                 accept;
  logic                 at_limit;
  logic                 cur_flagged;

  assign seg         = {x1, y1, z1, x2, y2, z2};
  assign limit       = ct - IDW'(1);
  assign at_limit    = (i == limit);
  assign cur_flagged = flag[i[AW-1:0]];
  assign full        = (ct == IDW'(MAX_LINES));
  assign accept      = (state == IDLE) && in_val && !full && !clr;

  // Next-state logic; clr overrides every other transition.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) state_d = SCAN;
      end
      SCAN: begin
        if (at_limit)          state_d = REPORT;
        else if (!cur_flagged) state_d = CHECK;
      end
      CHECK: begin
        if (chk_ack) state_d = chk_hit ? REPORT : SCAN;
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_comb begin
    in_rdy  = 1'b0;
    chk_req = 1'b0;
    chk_a   = '0;
    chk_b   = '0;
    out_val = 1'b0;
    busy    = (state != IDLE);
    case (state)
      IDLE:   in_rdy  = !full;
      CHECK: begin
        chk_req = 1'b1;
        chk_a   = cur;
        chk_b   = mem[i[AW-1:0]];
      end
      REPORT: out_val = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Table and scan bookkeeping; lineID and collide are latched on entry to REPORT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ct          <= '0;
      i           <= '0;
      flag        <= '0;
      cur         <= '0;
      collide     <= 1'b0;
      collide_cnt <= '0;
      lineID      <= '0;
    end else if (clr) begin
      ct          <= '0;
      i           <= '0;
      flag        <= '0;
      collide     <= 1'b0;
      collide_cnt <= '0;
      lineID      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur              <= seg;
            flag[ct[AW-1:0]] <= 1'b0;
            ct               <= ct + IDW'(1);
            i                <= '0;
          end
        end
        SCAN: begin
          if (at_limit) begin
            collide <= 1'b0;
            lineID  <= ct;
          end else if (cur_flagged) begin
            i <= i + IDW'(1);
          end
        end
        CHECK: begin
          if (chk_ack) begin
            if (chk_hit) begin
              flag[limit[AW-1:0]] <= 1'b1;
              collide             <= 1'b1;
              lineID              <= ct;
            end else begin
              i <= i + IDW'(1);
            end
          end
        end
        REPORT: begin
          if (collide && (collide_cnt != '1)) collide_cnt <= collide_cnt + IDW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[ct[AW-1:0]] <= seg;
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Self-checking bench for collision_scheduler: a checker model answers pair
// requests and a scoreboard of expected verdicts is compared on every out_val.
module tb_collision_scheduler;

  localparam int CW  = 8;
  localparam int IDW = 8;
  localparam int ML  = 51;
  localparam int SW  = 6 * CW;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_val;
  logic           in_rdy;
  logic [CW-1:0]  x1, y1, z1, x2, y2, z2;
  logic           clr;
  logic           chk_req;
  logic [SW-1:0]  chk_a, chk_b;
  logic           chk_ack, chk_hit;
  logic           out_val;
  logic [IDW-1:0] lineID;
  logic           collide;
  logic [IDW-1:0] collide_cnt;
  logic           full, busy;

  int vectors    = 0;
  int miscompares = 0;
  int model_ct   = 0;
  int ack_delay  = 0;
  int wait_cnt   = 0;
  logic [SW-1:0] pair_a, pair_b;
  logic [IDW:0]  sb [$];

  localparam logic [SW-1:0] SEG1 = {8'd0, 8'd0, 8'd0, 8'd10, 8'd10, 8'd0};
  localparam logic [SW-1:0] SEG2 = {8'd0, 8'd10, 8'd0, 8'd10, 8'd0, 8'd0};
  localparam logic [SW-1:0] SEG3 = {8'd20, 8'd20, 8'd0, 8'd30, 8'd30, 8'd0};
  localparam logic [SW-1:0] SEG4 = {8'd40, 8'd0, 8'd0, 8'd50, 8'd0, 8'd5};

  collision_scheduler #(.MAX_LINES(ML), .CW(CW), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
    .x1(x1), .y1(y1), .z1(z1), .x2(x2), .y2(y2), .z2(z2),
    .clr(clr), .chk_req(chk_req), .chk_a(chk_a), .chk_b(chk_b),
    .chk_ack(chk_ack), .chk_hit(chk_hit), .out_val(out_val),
    .lineID(lineID), .collide(collide), .collide_cnt(collide_cnt),
    .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  // Checker model: acks after ack_delay wait cycles, hits only on the armed pair.
  assign chk_ack = chk_req && (wait_cnt >= ack_delay);
  assign chk_hit = chk_ack && (chk_a == pair_a) && (chk_b == pair_b);

  always @(posedge clk) begin
    if (chk_req && !chk_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  // Scoreboard: every verdict must match the oldest expected {lineID, collide}.
  always @(negedge clk) begin
    if (out_val) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_verdict: got lineID=%0d collide=%0b, required none", lineID, collide);
      end else begin
        logic [IDW:0] exp_v;
        exp_v = sb.pop_front();
        if ({lineID, collide} !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL verdict: got lineID=%0d collide=%0b, required lineID=%0d collide=%0b",
                   lineID, collide, exp_v[IDW:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apply_segment(input logic [SW-1:0] seg, input logic exp_col,
                               output int lat, output int nreq,
                               output logic [SW-1:0] first_b, output logic stable);
    logic prev_req;
    logic [SW-1:0] prev_a, prev_b;
    @(negedge clk);
    {x1, y1, z1, x2, y2, z2} = seg;
    in_val = 1'b1;
    if (in_rdy) begin
      sb.push_back({IDW'(model_ct + 1), exp_col});
      model_ct++;
    end
    @(posedge clk);
    lat = -1; nreq = 0; stable = 1'b1; first_b = '0;
    prev_req = 1'b0; prev_a = '0; prev_b = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_val = 1'b0;
      if (out_val) begin
        lat = c + 1;
        break;
      end
      if (chk_req) begin
        if (nreq == 0) first_b = chk_b;
        if (prev_req && (chk_a !== prev_a || chk_b !== prev_b)) stable = 1'b0;
        nreq++;
        prev_a = chk_a;
        prev_b = chk_b;
      end
      prev_req = chk_req;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_rdy, busy, out_val, chk_req, full, collide} !== 6'b100000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got rdy/busy/oval/req/full/col=%b, required 100000",
               {in_rdy, busy, out_val, chk_req, full, collide});
    end
    vectors++;
    if ({lineID, collide_cnt, chk_a, chk_b} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_buses: got lineID=%0d cnt=%0d a=%h b=%h, required all 0",
               lineID, collide_cnt, chk_a, chk_b);
    end
    reset = 1'b1;
  endtask

  task automatic test_first();
    int lat, nreq; logic [SW-1:0] fb; logic st;
    apply_segment(SEG1, 1'b0, lat, nreq, fb, st);
    vectors++;
    if (lat !== 2 || nreq !== 0) begin
      miscompares++;
      $display("[TB] FAIL first_latency: got lat=%0d req=%0d, required lat=2 req=0", lat, nreq);
    end
    @(negedge clk);
    vectors++;
    if (in_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL first_rdy: got in_rdy=%b, required 1", in_rdy);
    end
  endtask

  task automatic test_hit();
    int lat, nreq; logic [SW-1:0] fb; logic st;
    pair_a = SEG2; pair_b = SEG1;
    apply_segment(SEG2, 1'b1, lat, nreq, fb, st);
    vectors++;
    if (lat !== 3 || nreq !== 1 || fb !== SEG1) begin
      miscompares++;
      $display("[TB] FAIL hit_scan: got lat=%0d req=%0d b=%h, required lat=3 req=1 b=%h", lat, nreq, fb, SEG1);
    end
    @(negedge clk);
    vectors++;
    if (collide_cnt !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL hit_count: got collide_cnt=%0d, required 1", collide_cnt);
    end
  endtask

  task automatic test_skip_flagged();
    int lat, nreq; logic [SW-1:0] fb; logic st;
    apply_segment(SEG3, 1'b0, lat, nreq, fb, st);
    vectors++;
    if (lat !== 5 || nreq !== 1 || fb !== SEG1) begin
      miscompares++;
      $display("[TB] FAIL skip_flagged: got lat=%0d req=%0d b=%h, required lat=5 req=1 b=%h", lat, nreq, fb, SEG1);
    end
  endtask

  task automatic test_ack_delay();
    int lat, nreq; logic [SW-1:0] fb; logic st;
    ack_delay = 3;
    apply_segment(SEG4, 1'b0, lat, nreq, fb, st);
    ack_delay = 0;
    vectors++;
    if (lat !== 13 || nreq !== 8) begin
      miscompares++;
      $display("[TB] FAIL ack_delay_timing: got lat=%0d req=%0d, required lat=13 req=8", lat, nreq);
    end
    vectors++;
    if (st !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ack_delay_stable: got stable=%b, required 1", st);
    end
  endtask

  task automatic test_full();
    int lat, nreq; logic [SW-1:0] fb; logic st; logic bad;
    int timeouts;
    timeouts = 0;
    while (model_ct < ML) begin
      apply_segment({8'(model_ct), 8'(model_ct + 1), 8'd200, 8'd7, 8'd9, 8'(model_ct)}, 1'b0, lat, nreq, fb, st);
      if (lat < 0) timeouts++;
    end
    vectors++;
    if (timeouts !== 0) begin
      miscompares++;
      $display("[TB] FAIL fill_timeout: got %0d timed-out segments, required 0", timeouts);
    end
    @(negedge clk);
    vectors++;
    if ({full, in_rdy, collide_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      miscompares++;
      $display("[TB] FAIL full_flags: got full=%b rdy=%b cnt=%0d, required full=1 rdy=0 cnt=1",
               full, in_rdy, collide_cnt);
    end
    {x1, y1, z1, x2, y2, z2} = SEG3;
    in_val = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_val || busy) bad = 1'b1;
    end
    in_val = 1'b0;
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_ignore: got activity=%b, required 0", bad);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_ct = 0;
    vectors++;
    if ({full, in_rdy, collide_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      miscompares++;
      $display("[TB] FAIL clr_state: got full=%b rdy=%b cnt=%0d, required full=0 rdy=1 cnt=0",
               full, in_rdy, collide_cnt);
    end
    apply_segment(SEG1, 1'b0, lat, nreq, fb, st);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("[TB] FAIL clr_first: got lat=%0d, required 2", lat);
    end
  endtask

  task automatic test_reset_mid_check();
    int lat, nreq; logic [SW-1:0] fb; logic st; logic seen;
    ack_delay = 10;
    @(negedge clk);
    {x1, y1, z1, x2, y2, z2} = SEG3;
    in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (chk_req) seen = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midcheck_req: got chk_req never, required chk_req=1");
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({chk_req, busy, out_val} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL midcheck_reset: got req/busy/oval=%b, required 000", {chk_req, busy, out_val});
    end
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    model_ct = 0;
    apply_segment(SEG2, 1'b0, lat, nreq, fb, st);
    vectors++;
    if (lat !== 2 || nreq !== 0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_first: got lat=%0d req=%0d, required lat=2 req=0", lat, nreq);
    end
  endtask

  initial begin
    in_val = 1'b0;
    clr = 1'b0;
    {x1, y1, z1, x2, y2, z2} = '0;
    pair_a = '1;
    pair_b = '1;
    test_reset();
    test_first();
    test_hit();
    test_skip_flagged();
    test_ack_delay();
    test_full();
    test_reset_mid_check();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL pending_verdicts: got %0d outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
